io_port_responder: RTL

//  Device-side end of the processor I/O interface. Accepts OUT-instruction writes
//  (update strobe + 16-bit data), buffers them in a FIFO and drains them to an

---
 rtl/io_port_responder.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/io_port_responder.sv
// io_port_responder
//   Device-side end of the processor I/O interface.
//   Write side: OUT-instruction writes (out_update strobe + out_data) are queued
//   in a DEPTH-entry FIFO and drained to an external sink over ext_valid/ext_ready.
//   Read side: asynchronous switches are synchronised (two flops), debounced and
//   presented to the processor as outside_input, with a one-cycle in_changed pulse.
//
// Ports
//   clock, reset        single clock; asynchronous active-high reset
//   out_update/out_data OUT write strobe and data
//   out_stall           FIFO full, processor must hold the OUT
//   ext_valid/ext_data  show-ahead head entry to the sink
//   ext_ready           sink accepts the head entry
//   fifo_count          occupancy 0..DEPTH
//   overflow            sticky dropped-write flag, cleared by overflow_clear
//   switch_in           asynchronous switches
//   outside_input       debounced switch value
//   in_changed          one-cycle pulse when outside_input updates
module io_port_responder #(
    parameter int DEPTH           = 8,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     out_update,
    input  logic [15:0]              out_data,
    output logic                     out_stall,
    output logic                     ext_valid,
    output logic [15:0]              ext_data,
    input  logic                     ext_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    input  logic                     overflow_clear,
    input  logic [15:0]              switch_in,
    output logic [15:0]              outside_input,
    output logic                     in_changed
);

    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = PW + 1;
    localparam int CNTW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {STABLE, SETTLING} deb_state_t;

    // FIFO state
    logic [15:0]   mem_q [DEPTH];
    logic [15:0]   mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;

    // Input path state
    logic [15:0]     sync1_q, sync1_d;
    logic [15:0]     sync2_q, sync2_d;
    logic [15:0]     cand_q, cand_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    deb_state_t      state_q, state_d;
    logic [15:0]     outside_q, outside_d;
    logic            changed_q, changed_d;

    logic full, pop, push, drop;

    always_comb begin
        full = (count_q == FULL_CNT);
        pop  = (count_q != '0) & ext_ready;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push = out_update & (~full | pop);
        drop = out_update & full & ~pop;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            mem_d[wr_ptr_q] = out_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end

        // Drop wins over a simultaneous clear so no lost write goes unreported.
        overflow_d = overflow_q;
        if (overflow_clear) overflow_d = 1'b0;
        if (drop)           overflow_d = 1'b1;
    end

    always_comb begin
        sync1_d   = switch_in;
        sync2_d   = sync1_q;
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        state_d   = state_q;
        outside_d = outside_q;
        changed_d = 1'b0;

        if (sync2_q != cand_q) begin
            // Any movement restarts settling, whatever the current state.
            cand_d  = sync2_q;
            cnt_d   = '0;
            state_d = SETTLING;
        end else if (state_q == SETTLING) begin
            if (cnt_q == CNT_LAST) begin
                state_d = STABLE;
                cnt_d   = '0;
                // A glitch that settles back on the old value is not a change.
                if (cand_q != outside_q) begin
                    outside_d = cand_q;
                    changed_d = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + CNTW'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            cand_q     <= '0;
            cnt_q      <= '0;
            state_q    <= STABLE;
            outside_q  <= '0;
            changed_q  <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            cand_q     <= cand_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            outside_q  <= outside_d;
            changed_q  <= changed_d;
        end
    end

    assign out_stall     = full;
    assign ext_valid     = (count_q != '0);
    assign ext_data      = mem_q[rd_ptr_q];
    assign fifo_count    = count_q;
    assign overflow      = overflow_q;
    assign outside_input = outside_q;
    assign in_changed    = changed_q;

endmodule
